// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-issue instruction fetch controller.
//
// Holds the architectural PC, issues one fetch at a time to instruction
// memory, hands the fetched word and its PC to decode, then waits for the
// next PC from execute/writeback. A misaligned next PC or a bus error sets a
// sticky fault and parks the block until reset.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req_*        fetch request (valid/ready), address = pc
//   imem_resp_*       fetch response: data word, error qualified by valid
//   inst_valid/ready  instruction handshake to decode; inst/pc held stable
//   npc_valid, npc    next PC from execute/writeback
//   fetch_fault       sticky fault flag
//   fetch_count       instructions delivered to decode (wraps)
module ifu_fetch_ctrl #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fetch_count
);

  typedef enum logic [2:0] {
    StReq,
    StWait,
    StOut,
    StNpc,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            req_valid_q;
  logic            inst_valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    count_d = count_q;
    unique case (state_q)
      StReq: begin
        // req_valid_q is low for the first cycle after reset, so gate on it.
        if (req_valid_q && imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            inst_d  = imem_resp_data;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (inst_valid_q && inst_ready) begin
          count_d = count_q + XLEN'(1);
          // A next PC arriving with the handshake skips the StNpc wait.
          if (npc_valid) begin
            if (npc[1:0] == 2'b00) begin
              pc_d    = npc;
              state_d = StReq;
            end else begin
              fault_d = 1'b1;
              state_d = StHalt;
            end
          end else begin
            state_d = StNpc;
          end
        end
      end
      StNpc: begin
        if (npc_valid) begin
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            state_d = StReq;
          end else begin
            fault_d = 1'b1;
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      fault_q      <= 1'b0;
      count_q      <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
      // Valids are decoded from the next state so they come straight off flops.
      req_valid_q  <= (state_d == StReq);
      inst_valid_q <= (state_d == StOut);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign fetch_fault    = fault_q;
  assign fetch_count    = count_q;

endmodule
